// File: rtl/adc_pp_pkg.sv
// Shared constants and types for the ADC post-processing slice.
//   DW            conversion result width
//   CHW / NCH     channel tag width / channel count (NCH == 2**CHW)
//   OSR_MAX_LOG2  largest oversampling exponent (128 samples)
//   ACC_W         accumulator width; holds 128 full-scale samples without wrap
package adc_pp_pkg;
  localparam int DW           = 10;
  localparam int CHW          = 3;
  localparam int NCH          = 8;
  localparam int OSR_MAX_LOG2 = 7;
  localparam int OSR_W        = 3;
  localparam int ACC_W        = DW + OSR_MAX_LOG2;
  localparam int CNT_W        = OSR_MAX_LOG2;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [DW-1:0]  data;
  } adc_res_t;

  // Sample-counter value of the final sample in a 2**osr window.
  function automatic logic [CNT_W-1:0] last_cnt(input logic [OSR_W-1:0] osr);
    logic [CNT_W:0] n;
    n = (CNT_W+1)'(1) << osr;
    return CNT_W'(n - 1'b1);
  endfunction
endpackage

// File: rtl/adc_window_cmp.sv
// Analog watchdog: compares each averaged result against [win_lo, win_hi]
// and keeps sticky per-channel out-of-window flags.
//   res_valid/res  registered average and its channel
//   win_en         per-channel check enable
//   win_lo/win_hi  inclusive bounds (lo > hi flags every average)
//   flag_clr       write-1-to-clear; a same-cycle set wins
//   win_flag/irq   sticky flags and their OR
module adc_window_cmp
  import adc_pp_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           res_valid,
  input  adc_res_t       res,
  input  logic [NCH-1:0] win_en,
  input  logic [DW-1:0]  win_lo,
  input  logic [DW-1:0]  win_hi,
  input  logic [NCH-1:0] flag_clr,
  output logic [NCH-1:0] win_flag,
  output logic           irq
);
  logic           oow;
  logic [NCH-1:0] set;

  always_comb begin
    oow = (res.data < win_lo) || (res.data > win_hi);
    set = '0;
    if (res_valid && win_en[res.ch] && oow) set[res.ch] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) win_flag <= '0;
    else        win_flag <= (win_flag & ~flag_clr) | set;
  end

  // Driven from flops only, no input-to-irq combinational path.
  assign irq = |win_flag;
endmodule

// File: rtl/adc_oversample_window.sv
// Per-channel oversampling averager with analog-watchdog window check.
// Each accepted sample is added to its channel's accumulator; the
// 2**osr_log2-th sample emits sum >> osr_log2 one cycle later.
//   en            low clears all accumulators/counters, drops samples
//   osr_log2      exponent; any change clears all state, drops that cycle's sample
//   in_valid/in_ch/in_data   conversion result pulse
//   out_valid/out_ch/out_data averaged result (data/ch held between pulses)
//   win_*/flag_clr/win_flag/irq  watchdog, see adc_window_cmp
module adc_oversample_window
  import adc_pp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [OSR_W-1:0] osr_log2,
  input  logic             in_valid,
  input  logic [CHW-1:0]   in_ch,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  output logic [CHW-1:0]   out_ch,
  output logic [DW-1:0]    out_data,
  input  logic [NCH-1:0]   win_en,
  input  logic [DW-1:0]    win_lo,
  input  logic [DW-1:0]    win_hi,
  input  logic [NCH-1:0]   flag_clr,
  output logic [NCH-1:0]   win_flag,
  output logic             irq
);
  logic [ACC_W-1:0] acc [NCH];
  logic [CNT_W-1:0] cnt [NCH];
  logic [OSR_W-1:0] osr_q;
  logic [1:0]       vld_pipe;
  adc_res_t         res_q;

  logic             clr_all, accept, is_last;
  logic [ACC_W-1:0] sum;
  logic [DW-1:0]    avg;

  always_comb begin
    clr_all     = !en || (osr_log2 != osr_q);
    accept      = in_valid && !clr_all;
    sum         = acc[in_ch] + ACC_W'(in_data);
    is_last     = (cnt[in_ch] == last_cnt(osr_log2));
    avg         = DW'(sum >> osr_log2);
    vld_pipe[0] = accept && is_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      osr_q       <= '0;
      vld_pipe[1] <= 1'b0;
      res_q       <= '0;
      for (int c = 0; c < NCH; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
    end else begin
      osr_q       <= osr_log2;
      vld_pipe[1] <= vld_pipe[0];
      if (clr_all) begin
        for (int c = 0; c < NCH; c++) begin
          acc[c] <= '0;
          cnt[c] <= '0;
        end
      end else if (accept) begin
        if (is_last) begin
          acc[in_ch] <= '0;
          cnt[in_ch] <= '0;
          res_q      <= '{ch: in_ch, data: avg};
        end else begin
          acc[in_ch] <= sum;
          cnt[in_ch] <= cnt[in_ch] + 1'b1;
        end
      end
    end
  end

  assign out_valid = vld_pipe[1];
  assign out_ch    = res_q.ch;
  assign out_data  = res_q.data;

  adc_window_cmp u_win (
    .clk      (clk),
    .rst_n    (rst_n),
    .res_valid(vld_pipe[1]),
    .res      (res_q),
    .win_en   (win_en),
    .win_lo   (win_lo),
    .win_hi   (win_hi),
    .flag_clr (flag_clr),
    .win_flag (win_flag),
    .irq      (irq)
  );
endmodule

// File: tb/tb_adc_oversample_window.sv
module tb_adc_oversample_window;
  import adc_pp_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [2:0]     osr_log2 = '0;
  logic           in_valid = 1'b0;
  logic [CHW-1:0] in_ch = '0;
  logic [DW-1:0]  in_data = '0;
  logic [NCH-1:0] win_en = '0;
  logic [DW-1:0]  win_lo = '0;
  logic [DW-1:0]  win_hi = '0;
  logic [NCH-1:0] flag_clr = '0;
  logic           out_valid;
  logic [CHW-1:0] out_ch;
  logic [DW-1:0]  out_data;
  logic [NCH-1:0] win_flag;
  logic           irq;

  adc_oversample_window dut (
    .clk(clk), .rst_n(rst_n), .en(en), .osr_log2(osr_log2),
    .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data),
    .win_en(win_en), .win_lo(win_lo), .win_hi(win_hi),
    .flag_clr(flag_clr), .win_flag(win_flag), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each channel keeps the list of samples in its window.
  int unsigned    mq [NCH][$];
  bit             m_ov;
  int unsigned    m_ch, m_data, m_flag, m_osr;

  function automatic void chk(string name, int unsigned act, int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) mq[c].delete();
    m_ov = 0; m_ch = 0; m_data = 0; m_flag = 0; m_osr = 0;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  function automatic void model_edge();
    int unsigned set, s;
    set = 0;
    if (m_ov && win_en[m_ch] && (m_data < win_lo || m_data > win_hi)) set = 1 << m_ch;
    m_flag = ((m_flag & ~int'(flag_clr)) | set) & 8'hFF;
    m_ov = 0;
    if (!en || osr_log2 != m_osr) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
    end else if (in_valid) begin
      mq[in_ch].push_back(in_data);
      if (mq[in_ch].size() == (1 << osr_log2)) begin
        s = 0;
        foreach (mq[in_ch][k]) s += mq[in_ch][k];
        m_ov = 1; m_ch = in_ch; m_data = (s / (1 << osr_log2)) & 10'h3FF;
        mq[in_ch].delete();
      end
    end
    m_osr = osr_log2;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk); #1;
    chk("out_valid", out_valid, m_ov);
    chk("out_ch",    out_ch,    m_ch);
    chk("out_data",  out_data,  m_data);
    chk("win_flag",  win_flag,  m_flag);
    chk("irq",       irq,       m_flag != 0);
    in_valid = 0;
    flag_clr = '0;
  endtask

  task automatic smp(input logic [CHW-1:0] c, input logic [DW-1:0] d);
    in_valid = 1; in_ch = c; in_data = d;
    tick();
  endtask

  typedef struct {
    bit             e;
    logic [2:0]     osr;
    bit             v;
    logic [CHW-1:0] ch;
    logic [DW-1:0]  d;
    bit             xov;
    logic [CHW-1:0] xch;
    logic [DW-1:0]  xd;
  } vec_t;
  vec_t tbl [8];

  int nov;

  initial begin
    model_reset();
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ch",    out_ch,    0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_win_flag",  win_flag,  0);
    chk("rst_irq",       irq,       0);
    en = 1; rst_n = 1;
    @(posedge clk); #1;

    // Pass-through and osr=2 averaging, fixed vectors.
    tbl[0] = '{1, 0, 1, 2, 10'h155, 1, 2, 10'h155};
    tbl[1] = '{1, 0, 0, 0, 10'h000, 0, 2, 10'h155};
    tbl[2] = '{1, 2, 0, 0, 10'h000, 0, 2, 10'h155};
    tbl[3] = '{1, 2, 1, 5, 10'd100, 0, 2, 10'h155};
    tbl[4] = '{1, 2, 1, 5, 10'd101, 0, 2, 10'h155};
    tbl[5] = '{1, 2, 1, 5, 10'd102, 0, 2, 10'h155};
    tbl[6] = '{1, 2, 1, 5, 10'd104, 1, 5, 10'd101};
    tbl[7] = '{1, 2, 0, 0, 10'h000, 0, 5, 10'd101};
    win_en = 8'h04; win_lo = 10'h100; win_hi = 10'h200;
    for (int i = 0; i < 8; i++) begin
      en = tbl[i].e; osr_log2 = tbl[i].osr;
      in_valid = tbl[i].v; in_ch = tbl[i].ch; in_data = tbl[i].d;
      tick();
      chk($sformatf("tbl%0d_ov", i), out_valid, tbl[i].xov);
      chk($sformatf("tbl%0d_ch", i), out_ch,    tbl[i].xch);
      chk($sformatf("tbl%0d_d",  i), out_data,  tbl[i].xd);
    end
    chk("pass_no_flag", win_flag, 0);

    // osr=7, full-scale ch0 interleaved with random ch1.
    win_en = '0; osr_log2 = 7; tick();
    for (int i = 0; i < 128; i++) begin
      smp(0, 10'h3FF);
      if (i == 127) begin
        chk("osr7_ch0_ov", out_valid, 1);
        chk("osr7_ch0_d",  out_data,  10'h3FF);
      end
      smp(1, DW'($urandom));
    end
    chk("osr7_ch1_ch", out_ch, 1);

    // osr change discards the partial window.
    osr_log2 = 1; tick();
    smp(3, 10);
    osr_log2 = 2; tick();
    for (int i = 0; i < 4; i++) smp(3, 20);
    chk("osrchg_ov", out_valid, 1);
    chk("osrchg_d",  out_data,  20);

    // Watchdog set, set-beats-clear, lone clear.
    win_en = 8'h10; win_lo = 10'h080; win_hi = 10'h300;
    osr_log2 = 0; tick();
    smp(4, 10'h050);
    tick();
    chk("wd_flag", win_flag[4], 1);
    chk("wd_irq",  irq, 1);
    smp(4, 10'h050);
    flag_clr = 8'h10; tick();
    chk("wd_setwins", win_flag[4], 1);
    flag_clr = 8'h10; tick();
    chk("wd_clr", win_flag[4], 0);
    chk("wd_clr_irq", irq, 0);

    // en drop mid-window, then reset mid-run.
    win_en = 8'hFF; win_lo = 10'h3FF; win_hi = 10'h000;
    osr_log2 = 3; tick();
    for (int i = 0; i < 5; i++) smp(6, DW'(i * 7));
    en = 0; tick(); tick();
    en = 1;
    nov = 0;
    for (int i = 0; i < 7; i++) begin
      smp(6, DW'(i + 40));
      nov += out_valid;
    end
    chk("en_no_early_ov", nov, 0);
    smp(6, 10'd47);
    chk("en_ov_8th", out_valid, 1);
    chk("en_avg", out_data, 10'd43);
    tick();
    chk("en_flag_pre_rst", win_flag[6], 1);
    smp(2, 10'h111);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("mid_rst_ov",   out_valid, 0);
    chk("mid_rst_ch",   out_ch,    0);
    chk("mid_rst_d",    out_data,  0);
    chk("mid_rst_flag", win_flag,  0);
    chk("mid_rst_irq",  irq,       0);
    #1 rst_n = 1;

    // Randomized run against the model.
    for (int n = 0; n < 800; n++) begin
      en = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 49) == 0) begin
        osr_log2 = 3'($urandom_range(0, 3));
        win_lo = DW'($urandom); win_hi = DW'($urandom);
        win_en = NCH'($urandom);
      end
      in_valid = ($urandom_range(0, 3) != 0);
      in_ch = CHW'($urandom);
      in_data = DW'($urandom);
      if ($urandom_range(0, 9) == 0) flag_clr = NCH'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
